timebase_ctrl: RTL
==================

// Module: timebase_ctrl
// PURPOSE
//   Run/stop/single-step controller for the free-running board timebase.
//   Replaces the bare 28-bit counter with a programmable prescaler whose divide
//   value loads through a valid/ready handshake.
//   Emits a one-cycle tick enable and a wrapping phase count; the count drives
//   the LED/display logic in place of the high counter bits.
// PARAMETERS
//   DIV_W        28            width of prescaler and divide register
//   DEFAULT_DIV  33554431      divide value after reset (period = DIV+1 clk cycles)
//   OUT_W        3             width of phase count output
// PORTS
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       1-cycle pulse: enter RUN
//   stop       in   1       1-cycle pulse: return to IDLE (pause)
//   step       in   1       1-cycle pulse: run exactly one tick period
//   div_value  in   DIV_W   new divide value
//   div_valid  in   1       div_value valid
//   div_ready  out  1       divide load accepted when div_valid & div_ready
//   tick       out  1       1-cycle pulse at end of each period
//   count      out  OUT_W   phase count, increments with each tick
//   running    out  1       high in RUN or STEP
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - state=IDLE, pre_cnt=0, div_reg=DEFAULT_DIV.
//   - tick=0, count=0, running=0, div_ready=1.
//   States and transitions (priority stop > start > step):
//   - IDLE: start -> RUN; step -> STEP.
//   - RUN: stop -> IDLE; start and step are ignored.
//   - STEP: stop -> IDLE; terminal count -> IDLE. start and step are ignored.
//   Prescaler (registered; evaluated on the current state):
//   - In RUN/STEP at a rising edge with pre_cnt==div_reg: pre_cnt<=0, tick<=1,
//     count<=count+1 (mod 2^OUT_W, wraps max->0).
//   - Otherwise in RUN/STEP: pre_cnt<=pre_cnt+1, tick<=0.
//   - In IDLE: pre_cnt holds, tick<=0, count holds.
//   - Tick period is div_reg+1 cycles. div_reg==0 gives tick every cycle in RUN.
//   - Stop never clears pre_cnt. A later start or step resumes mid-period.
//   Divide load handshake:
//   - div_ready = (state==IDLE), derived from the state register.
//   - Transfer on an edge with div_valid & div_ready: div_reg<=div_value, pre_cnt<=0.
//   - div_valid outside IDLE is held off. The value is not captured.
//   - A transfer and start/step in the same cycle both take effect: new div_reg, RUN/STEP.
//   Boundary conditions:
//   - stop on the terminal-count edge: tick still fires (count increments); next state IDLE.
//   - STEP reaching terminal count: exactly one tick, then IDLE with pre_cnt=0.
//   - Reset mid-period: all registers return immediately to reset values. No tick is produced.
//   - running = (state!=IDLE), derived from the state register.
// TESTING
//   1 Reset, load div=3, start: tick on every 4th cycle.
//     count 0->1->..->7->0 (wrap checked).
//   2 div=3, RUN, stop 2 cycles after a tick, wait 10 cycles, start:
//     next tick 2 cycles after RUN re-entry (pre_cnt held).
//   3 IDLE, pre_cnt=0, div=4, step: exactly one tick 5 cycles later.
//     Then running=0, count+1. No further ticks over 20 cycles.
//   4 RUN with div_valid=1, div_value=0: div_ready=0, div_reg unchanged.
//     After stop: transfer the next cycle. On start: tick every cycle.
//   5 Same-cycle start+stop in IDLE stays IDLE. stop on the terminal edge gives one tick, then IDLE.
//   6 Assert rst_n=0 mid-period during RUN: outputs reset asynchronously.
//     div_reg=DEFAULT_DIV, div_ready=1 before the next clk edge.

Source files
------------

// File: rtl/timebase_ctrl.sv
// Run/stop/single-step timebase: programmable prescaler emitting a tick pulse and a wrapping phase count.
// Latency: tick and count update one clk after the edge where pre_cnt reaches div_reg; period is div_reg+1 cycles.
// Backpressure: div_ready is high only in IDLE; div_valid is held off (value not captured) while running.
module timebase_ctrl #(
    parameter int          DIV_W       = 28,
    parameter int unsigned DEFAULT_DIV = 33554431,
    parameter int          OUT_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [DIV_W-1:0] div_value,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             tick,
    output logic [OUT_W-1:0] count,
    output logic             running
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] pre_cnt;
    logic [DIV_W-1:0] div_reg;
    logic             terminal;

    // End of the current period: the prescaler has reached the programmed divide value.
    assign terminal  = (pre_cnt == div_reg);

    // Both status outputs decode straight from the state register so they never lag the FSM.
    assign div_ready = (state == ST_IDLE);
    assign running   = (state != ST_IDLE);

    // Control FSM, prescaler, divide register and phase count; stop beats start beats step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pre_cnt <= '0;
            div_reg <= DIV_W'(DEFAULT_DIV);
            tick    <= 1'b0;
            count   <= '0;
        end else begin
            tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Prescaler is frozen here; a new divide value restarts the period from zero.
                    if (div_valid) begin
                        div_reg <= div_value;
                        pre_cnt <= '0;
                    end
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (start) begin
                        state <= ST_RUN;
                    end else if (step) begin
                        state <= ST_STEP;
                    end
                end
                ST_RUN, ST_STEP: begin
                    // A terminal edge always produces its tick, even when stop arrives on the same edge.
                    if (terminal) begin
                        pre_cnt <= '0;
                        tick    <= 1'b1;
                        count   <= count + 1'b1;
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                    // pre_cnt is deliberately kept on stop so a later start/step resumes mid-period.
                    if (stop || ((state == ST_STEP) && terminal)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
